// File: rtl/tow_playfield_if.sv
// rtl/tow_playfield_if.sv - command and display bundle between the tug-of-war delegator and playfield
interface tow_playfield_if #(
  parameter int N = 9
);
  logic [2:0]   cmd;
  logic         deviate1;
  logic         deviate2;
  logic [N-1:0] leds;
  logic         win1;
  logic         win2;
  logic [2:0]   score1;
  logic [2:0]   score2;
  logic         game_over;
  logic         illegal_cmd;

  modport master (
    output cmd,
    input  deviate1, deviate2, leds, win1, win2, score1, score2, game_over, illegal_cmd
  );

  modport slave (
    input  cmd,
    output deviate1, deviate2, leds, win1, win2, score1, score2, game_over, illegal_cmd
  );
endinterface

// File: rtl/tow_playfield.sv
// rtl/tow_playfield.sv - tug-of-war playfield: rope light, round wins, scores and game-over latch
module tow_playfield #(
  parameter int N           = 9,
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_SCORE   = 7
) (
  input  logic           clk,
  input  logic           reset,
  tow_playfield_if.slave bus
);
  localparam int PW = (N > 2) ? $clog2(N) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [PW-1:0] CENTER = PW'((N - 1) / 2);
  localparam logic [PW-1:0] LAST   = PW'(N - 1);
  localparam logic [HW-1:0] HOLD_P = HW'(HOLD_CYCLES);
  localparam logic [2:0]    MAX_P  = 3'(MAX_SCORE);

  typedef enum logic [1:0] {PLAY, WIN1, WIN2, OVER} state_t;

  state_t        state;
  logic [PW-1:0] pos;
  logic [HW-1:0] hold;
  logic [2:0]    score1, score2;
  logic          win1, win2, game_over, illegal_cmd;
  logic          is_up, is_down, is_illegal;
  logic [2:0]    winner_score;

  always_comb begin
    is_up      = 1'b0;
    is_down    = 1'b0;
    is_illegal = 1'b0;
    case (bus.cmd)
      3'b001, 3'b110: is_up      = 1'b1;
      3'b111, 3'b000: is_down    = 1'b1;
      3'b100:         ;
      default:        is_illegal = 1'b1;
    endcase
  end

  assign winner_score = (state == WIN1) ? score1 : score2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PLAY;
      pos         <= CENTER;
      hold        <= '0;
      score1      <= '0;
      score2      <= '0;
      win1        <= 1'b0;
      win2        <= 1'b0;
      game_over   <= 1'b0;
      illegal_cmd <= 1'b0;
    end else begin
      illegal_cmd <= 1'b0;
      case (state)
        PLAY: begin
          illegal_cmd <= is_illegal;
          if (is_up) begin
            if (pos == LAST) begin
              score1 <= score1 + 3'd1;
              hold   <= HOLD_P;
              win1   <= 1'b1;
              state  <= WIN1;
            end else begin
              pos <= pos + PW'(1);
            end
          end else if (is_down) begin
            if (pos == '0) begin
              score2 <= score2 + 3'd1;
              hold   <= HOLD_P;
              win2   <= 1'b1;
              state  <= WIN2;
            end else begin
              pos <= pos - PW'(1);
            end
          end
        end
        WIN1, WIN2: begin
          hold <= hold - HW'(1);
          // Last display cycle: either finish the game or start a fresh round.
          if (hold == HW'(1)) begin
            if (winner_score == MAX_P) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              pos   <= CENTER;
              win1  <= 1'b0;
              win2  <= 1'b0;
              state <= PLAY;
            end
          end
        end
        OVER: ;
        default: state <= PLAY;
      endcase
    end
  end

  // pos already sits at the winner's end in WIN/OVER, so one decode covers every state.
  assign bus.leds        = N'(1) << pos;
  assign bus.deviate1    = (state == PLAY) && (pos == CENTER + PW'(1));
  assign bus.deviate2    = (state == PLAY) && (pos == CENTER - PW'(1));
  assign bus.win1        = win1;
  assign bus.win2        = win2;
  assign bus.score1      = score1;
  assign bus.score2      = score2;
  assign bus.game_over   = game_over;
  assign bus.illegal_cmd = illegal_cmd;
endmodule

// File: tb/tb_tow_playfield.sv
// tb/tb_tow_playfield.sv - scoreboard bench for tow_playfield (N=9, HOLD_CYCLES=4, MAX_SCORE=2)
module tb_tow_playfield;
  localparam int N    = 9;
  localparam int HOLD = 4;
  localparam int MAXS = 2;
  localparam int CTR  = (N - 1) / 2;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  tow_playfield_if #(.N(N)) bus ();

  tow_playfield #(.N(N), .HOLD_CYCLES(HOLD), .MAX_SCORE(MAXS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [N-1:0] leds;
    logic         d1, d2, w1, w2, go, ill;
    logic [2:0]   s1, s2;
  } exp_t;

  exp_t sb[$];

  // Reference model: 0=play 1=win1 2=win2 3=over
  int m_st, m_pos, m_s1, m_s2, m_hold, m_winner;
  bit m_ill;

  task automatic model_cycle(input bit rst, input logic [2:0] c);
    bit up, dn, bad;
    up  = (c == 3'b001) || (c == 3'b110);
    dn  = (c == 3'b111) || (c == 3'b000);
    bad = !up && !dn && (c != 3'b100);
    if (rst) begin
      m_st = 0; m_pos = CTR; m_s1 = 0; m_s2 = 0; m_hold = 0; m_winner = 0; m_ill = 0;
    end else begin
      m_ill = (m_st == 0) && bad;
      if (m_st == 0) begin
        if (up && m_pos == N - 1) begin
          m_s1++; m_hold = HOLD; m_st = 1; m_winner = 1;
        end else if (up) begin
          m_pos++;
        end else if (dn && m_pos == 0) begin
          m_s2++; m_hold = HOLD; m_st = 2; m_winner = 2;
        end else if (dn) begin
          m_pos--;
        end
      end else if (m_st == 1 || m_st == 2) begin
        if (m_hold == 1) begin
          if ((m_winner == 1 ? m_s1 : m_s2) == MAXS) m_st = 3;
          else begin m_st = 0; m_pos = CTR; m_winner = 0; end
        end
        m_hold--;
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.leds = '0;
    e.leds[m_pos] = 1'b1;
    e.d1  = (m_st == 0) && (m_pos == CTR + 1);
    e.d2  = (m_st == 0) && (m_pos == CTR - 1);
    e.w1  = (m_winner == 1);
    e.w2  = (m_winner == 2);
    e.go  = (m_st == 3);
    e.ill = m_ill;
    e.s1  = 3'(m_s1);
    e.s2  = 3'(m_s2);
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("leds",        32'(bus.leds),        32'(e.leds));
      check("deviate1",    32'(bus.deviate1),    32'(e.d1));
      check("deviate2",    32'(bus.deviate2),    32'(e.d2));
      check("win1",        32'(bus.win1),        32'(e.w1));
      check("win2",        32'(bus.win2),        32'(e.w2));
      check("score1",      32'(bus.score1),      32'(e.s1));
      check("score2",      32'(bus.score2),      32'(e.s2));
      check("game_over",   32'(bus.game_over),   32'(e.go));
      check("illegal_cmd", 32'(bus.illegal_cmd), 32'(e.ill));
    end
  endtask

  task automatic step(input logic [2:0] c);
    bus.cmd = c;
    model_cycle(1'b0, c);
    push_expected();
    @(posedge clk);
    #1;
    pop_compare();
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.cmd = 3'b100;
    model_cycle(1'b1, 3'b100);
    push_expected();
    @(posedge clk);
    #1;
    pop_compare();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    bus.cmd = 3'b100;
    do_reset();
    check("rst_leds", 32'(bus.leds), 32'(9'b000010000));

    for (int i = 0; i < 5; i++) step(3'b100);
    check("idle_leds", 32'(bus.leds), 32'(9'b000010000));

    step(3'b001);
    check("one_up_leds", 32'(bus.leds), 32'(9'b000100000));
    check("one_up_dev1", 32'(bus.deviate1), 32'd1);
    step(3'b000);
    check("back_center", 32'(bus.leds), 32'(9'b000010000));

    // Player1 round: four steps to the end, fifth wins.
    for (int i = 0; i < 4; i++) step(3'b001);
    check("at_end_no_win", 32'(bus.win1), 32'd0);
    step(3'b001);
    check("win1_set", 32'(bus.win1), 32'd1);
    check("score1_one", 32'(bus.score1), 32'd1);
    step(3'b111);
    step(3'b010);
    check("no_ill_in_win", 32'(bus.illegal_cmd), 32'd0);
    step(3'b111);
    check("win1_held", 32'(bus.win1), 32'd1);
    step(3'b111);
    check("win1_cleared", 32'(bus.win1), 32'd0);
    check("win1_center", 32'(bus.leds), 32'(9'b000010000));

    // Player2: reach 0, step back, then two downs to win.
    for (int i = 0; i < 4; i++) step(3'b111);
    check("pos0", 32'(bus.leds), 32'(9'b000000001));
    step(3'b110);
    check("pos1_dev2", 32'(bus.deviate2), 32'd0);
    step(3'b111);
    step(3'b111);
    check("win2_set", 32'(bus.win2), 32'd1);
    check("score2_one", 32'(bus.score2), 32'd1);
    for (int i = 0; i < HOLD; i++) step(3'b001);

    step(3'b010);
    check("ill_pulse", 32'(bus.illegal_cmd), 32'd1);
    check("ill_pos", 32'(bus.leds), 32'(9'b000010000));
    step(3'b100);
    check("ill_one_cycle", 32'(bus.illegal_cmd), 32'd0);
    step(3'b011);
    step(3'b101);

    // Player1 second win reaches MAX_SCORE.
    for (int i = 0; i < 5; i++) step(3'b110);
    check("score1_two", 32'(bus.score1), 32'd2);
    for (int i = 0; i < HOLD; i++) step(3'b000);
    check("game_over", 32'(bus.game_over), 32'd1);
    check("over_win1", 32'(bus.win1), 32'd1);
    check("over_leds", 32'(bus.leds), 32'(9'b100000000));
    step(3'b000);
    step(3'b010);
    step(3'b111);
    check("over_frozen", 32'(bus.score1), 32'd2);

    do_reset();
    check("rst_over_go", 32'(bus.game_over), 32'd0);
    step(3'b001);
    step(3'b001);
    do_reset();
    step(3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
